// File: rtl/step_sequencer.sv
// step_sequencer: multi-voice drum step sequencer.
// A NUM_VOICES x STEPS hit pattern is played one step every TICK_DIV clocks.
// Each step opens with a one-cycle GAP (enables low, step_pulse high) so a
// sample player retriggers on back-to-back hits of the same voice, followed
// by PLAY cycles that drive the column captured during GAP.
// Optional feature: define STEP_SEQUENCER_SWING_EN to lengthen even steps and
// shorten odd steps by SWING cycles; otherwise SWING is ignored.
// Write port: wr_en is a single-cycle strobe with no back-pressure; the bit
// is stored at the clock edge that samples wr_en high and is readable the
// following cycle.
module step_sequencer #(
  parameter int NUM_VOICES = 4,
  parameter int STEPS      = 16,
  parameter int TICK_DIV   = 6000,
  parameter int SWING      = 0,
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  wr_en,
  input  logic [VW-1:0]         wr_voice,
  input  logic [SW-1:0]         wr_step,
  input  logic                  wr_data,
  output logic [NUM_VOICES-1:0] enable,
  output logic [SW-1:0]         step_idx,
  output logic                  step_pulse,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    PLAY = 2'd2
  } state_e;

  // Counter wide enough for the longest (swung) step.
  localparam int PMAX = TICK_DIV + SWING;
  localparam int CW   = $clog2(PMAX + 1);

`ifdef STEP_SEQUENCER_SWING_EN
  localparam logic [CW-1:0] P_EVEN = CW'(TICK_DIV + SWING);
  localparam logic [CW-1:0] P_ODD  = CW'(TICK_DIV - SWING);
`else
  localparam logic [CW-1:0] P_EVEN = CW'(TICK_DIV);
  localparam logic [CW-1:0] P_ODD  = CW'(TICK_DIV);
`endif

  state_e                  state_q, state_d;
  logic [CW-1:0]           tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]           step_idx_q, step_idx_d;
  logic [NUM_VOICES-1:0]   enable_q;
  logic                    step_pulse_q;
  logic [NUM_VOICES-1:0]   pat_q [STEPS];
  logic [CW-1:0]           period_cur;
  logic                    last_tick;

  assign period_cur = step_idx_q[0] ? P_ODD : P_EVEN;
  assign last_tick  = (tick_cnt_q == period_cur - CW'(1));

  // Pattern store: one column (all voices) per step, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STEPS; s++) begin
        pat_q[s] <= '0;
      end
    end else if (wr_en && (int'(wr_voice) < NUM_VOICES)) begin
      pat_q[wr_step][wr_voice] <= wr_data;
    end
  end

  // Next-state logic: IDLE -> GAP -> PLAY ... -> GAP, run low aborts to IDLE.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    step_idx_d = step_idx_q;
    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        step_idx_d = '0;
        if (run) state_d = GAP;
      end
      GAP: begin
        if (!run) begin
          state_d    = IDLE;
          tick_cnt_d = '0;
          step_idx_d = '0;
        end else begin
          state_d    = PLAY;
          tick_cnt_d = CW'(1);
        end
      end
      PLAY: begin
        if (!run) begin
          state_d    = IDLE;
          tick_cnt_d = '0;
          step_idx_d = '0;
        end else if (last_tick) begin
          state_d    = GAP;
          tick_cnt_d = '0;
          step_idx_d = (step_idx_q == SW'(STEPS - 1)) ? '0 : step_idx_q + SW'(1);
        end else begin
          tick_cnt_d = tick_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        tick_cnt_d = '0;
        step_idx_d = '0;
      end
    endcase
  end

  // State and registered outputs; the enable column is captured leaving GAP,
  // so a write landing on that same edge only shows on the next visit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      step_idx_q   <= '0;
      enable_q     <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      step_idx_q   <= step_idx_d;
      step_pulse_q <= (state_d == GAP);
      if (state_q == GAP && state_d == PLAY) begin
        enable_q <= pat_q[step_idx_q];
      end else if (state_d != PLAY) begin
        enable_q <= '0;
      end
    end
  end

  assign enable     = enable_q;
  assign step_idx   = step_idx_q;
  assign step_pulse = step_pulse_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer (NUM_VOICES=2, STEPS=4, TICK_DIV=4, SWING=1).
// Reference model tracks playback as "cycles since the step-0 GAP" and maps
// that position to (step, phase) by walking the step periods.
module tb_step_sequencer;

  localparam int NV  = 2;
  localparam int ST  = 4;
  localparam int TD  = 4;
  localparam int SWG = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          wr_en;
  logic [0:0]    wr_voice;
  logic [1:0]    wr_step;
  logic          wr_data;
  logic [NV-1:0] enable;
  logic [1:0]    step_idx;
  logic          step_pulse;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int            m_pos;
  logic          m_pat [NV][ST];
  logic [NV-1:0] m_snap;

  step_sequencer #(
    .NUM_VOICES(NV), .STEPS(ST), .TICK_DIV(TD), .SWING(SWG)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .wr_en(wr_en), .wr_voice(wr_voice),
    .wr_step(wr_step), .wr_data(wr_data), .enable(enable),
    .step_idx(step_idx), .step_pulse(step_pulse), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic int period_of(input int s);
`ifdef STEP_SEQUENCER_SWING_EN
    return (s % 2 == 0) ? TD + SWG : TD - SWG;
`else
    return TD;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic locate(input int pos, output int idx, output int ph);
    idx = 0;
    ph  = pos;
    while (ph >= period_of(idx)) begin
      ph  = ph - period_of(idx);
      idx = (idx + 1) % ST;
    end
  endtask

  task automatic model_reset();
    m_pos  = -1;
    m_snap = '0;
    for (int v = 0; v < NV; v++)
      for (int s = 0; s < ST; s++)
        m_pat[v][s] = 1'b0;
  endtask

  // advance the model by one clock edge using the inputs now applied
  task automatic model_edge();
    int idx, ph;
    if (wr_en) m_pat[wr_voice][wr_step] = wr_data;
    if (!run) m_pos = -1;
    else m_pos = m_pos + 1;
    if (m_pos >= 0) begin
      locate(m_pos, idx, ph);
      if (ph == 0)
        for (int v = 0; v < NV; v++) m_snap[v] = m_pat[v][idx];
    end
  endtask

  task automatic check_outputs(input string tag);
    int idx, ph;
    logic [NV-1:0] e_en;
    logic [1:0]    e_step;
    logic          e_pulse;
    if (m_pos < 0) begin
      e_en = '0; e_step = '0; e_pulse = 1'b0;
    end else begin
      locate(m_pos, idx, ph);
      e_step  = 2'(idx);
      e_pulse = (ph == 0);
      e_en    = (ph == 0) ? '0 : m_snap;
    end
    check({tag, ".enable"}, 32'(enable), 32'(e_en));
    check({tag, ".step_idx"}, 32'(step_idx), 32'(e_step));
    check({tag, ".step_pulse"}, 32'(step_pulse), 32'(e_pulse));
  endtask

  // driver: apply inputs on the falling edge, model at rising edge, check after
  task automatic cycle(input string tag, input logic r, input logic we,
                       input logic [0:0] v, input logic [1:0] s, input logic d);
    @(negedge clk);
    run = r; wr_en = we; wr_voice = v; wr_step = s; wr_data = d;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; wr_en = 1'b0; wr_voice = '0; wr_step = '0; wr_data = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int idx, ph, prev_k, prev_step, k;
    rst = 1'b1; run = 1'b0; wr_en = 1'b0; wr_voice = '0; wr_step = '0; wr_data = 1'b0;
    model_reset();
    do_reset();

    // pattern voice0 steps 0,1 then play 16 steps, measuring step periods
    cycle("wr", 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    cycle("wr", 1'b0, 1'b1, 1'b0, 2'd1, 1'b1);
    prev_k = -1; prev_step = 0;
    for (k = 0; k < 16 * (TD + SWG) && k < 70; k++) begin
      cycle("play", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      if (step_pulse) begin
        if (prev_k >= 0) check("period", 32'(k - prev_k), 32'(period_of(prev_step)));
        prev_k = k; prev_step = int'(step_idx);
      end
    end

    // drop run at tick 2 of step 2, then restart from step 0
    for (k = 0; k < 40; k++) begin
      locate(m_pos, idx, ph);
      if (idx == 2 && ph == 2) break;
      cycle("seek", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    end
    cycle("stop", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    check("stop.state", 32'(dbg_state), 32'd0);
    for (k = 0; k < 6; k++) cycle("restart", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

    // write voice1 step1 during step1's GAP: must show only on the next visit
    cycle("stop2", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (k = 0; k < 2 * ST * (TD + SWG); k++) begin
      locate(m_pos < 0 ? 0 : m_pos, idx, ph);
      if (m_pos >= 0 && idx == 1 && ph == 0 && k < 10)
        cycle("gapwr", 1'b1, 1'b1, 1'b1, 2'd1, 1'b1);
      else
        cycle("gapwr", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    end

    // asynchronous reset mid-PLAY, away from any clock edge
    for (k = 0; k < 20; k++) begin
      locate(m_pos, idx, ph);
      if (ph == 2) break;
      cycle("seek2", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("async_rst");
    do_reset();
    for (k = 0; k < 2 * ST * (TD + SWG); k++) cycle("post_rst", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

    // randomized run/write traffic
    for (k = 0; k < 800; k++) begin
      cycle("rand", ($urandom_range(0, 29) != 0), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
